// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the level-tracking FIFO.
// Holds FWFT mode constants and pointer/level width functions.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_level.sv
// Synchronous FIFO with occupancy level, almost flags and sticky errors.
// Ports: clk, reset (async low), clk_enable, write/read, write_data,
// read_data, empty/full/almost_empty/almost_full, level,
// overflow/underflow, err_clear. Macro FIFO_ERROR_FLAGS_EN enables
// the sticky error flags; otherwise they read 0.
module fifo_level
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH        = 8,
  parameter int FIFO_DATA_WIDTH   = 8,
  parameter int ALMOSTFULL_DEPTH  = 3,
  parameter int ALMOSTEMPTY_DEPTH = 3,
  parameter int FWFT              = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_enable,
  input  logic                         write,
  input  logic                         read,
  input  logic [FIFO_DATA_WIDTH-1:0]   write_data,
  output logic [FIFO_DATA_WIDTH-1:0]   read_data,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic [lvl_w(FIFO_DEPTH)-1:0] level,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         err_clear
);

  localparam int AW = ptr_w(FIFO_DEPTH);
  localparam int LW = lvl_w(FIFO_DEPTH);

  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] AF_LVL   =
    LW'(FIFO_DEPTH - ALMOSTFULL_DEPTH);
  localparam logic [LW-1:0] AE_LVL   = LW'(ALMOSTEMPTY_DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]              wptr;
  logic [AW-1:0]              rptr;
  logic [FIFO_DATA_WIDTH-1:0] head;
  logic                       rd_acc;
  logic                       wr_acc;

  assign empty        = (level == '0);
  assign full         = (level == FULL_LVL);
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  // A write into a full FIFO still lands when the head leaves
  // on the same edge.
  assign rd_acc = read & ~empty;
  assign wr_acc = write & (~full | rd_acc);

  fifo_ram #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(FIFO_DATA_WIDTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc & clk_enable),
    .waddr(wptr),
    .wdata(write_data),
    .raddr(rptr),
    .rdata(head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clk_enable) begin
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (rd_acc) rptr <= rptr + PTR_ONE;
      unique case ({wr_acc, rd_acc})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  if (FWFT == FWFT_ON) begin : g_fwft
    // Remembers the last popped word so the output holds once empty.
    logic [FIFO_DATA_WIDTH-1:0] last;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        last <= '0;
      end else if (clk_enable && rd_acc) begin
        last <= head;
      end
    end

    assign read_data = empty ? last : head;
  end else begin : g_reg
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        read_data <= '0;
      end else if (clk_enable && rd_acc) begin
        read_data <= head;
      end
    end
  end

`ifdef FIFO_ERROR_FLAGS_EN
  logic ovf_set;
  logic unf_set;

  assign ovf_set = write & full & ~rd_acc;
  assign unf_set = read & empty;

  // A fresh error wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clk_enable) begin
      if (ovf_set)        overflow <= 1'b1;
      else if (err_clear) overflow <= 1'b0;
      if (unf_set)        underflow <= 1'b1;
      else if (err_clear) underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clear;

  assign unused_err_clear = err_clear;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

// File: doc/fifo_level.md
FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of entries; power of two, >= 2.
REQ-002 SHALL have parameter FIFO_DATA_WIDTH, default 8, data bits per entry.
REQ-003 SHALL have parameter ALMOSTFULL_DEPTH, default 3, free-entry margin for almost_full.
REQ-004 SHALL have parameter ALMOSTEMPTY_DEPTH, default 3, occupancy margin for almost_empty.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port clk_enable  input  1  when 0, all state holds.
REQ-009 SHALL have ports write / read  input  1 each  push / pop requests.
REQ-010 SHALL have ports write_data input and read_data output, both FIFO_DATA_WIDTH bits.
REQ-011 SHALL have outputs empty, full, almost_empty, almost_full, 1 bit each.
REQ-012 SHALL have output level  $clog2(FIFO_DEPTH)+1 bits  current occupancy, 0..FIFO_DEPTH.
REQ-013 SHALL have outputs overflow / underflow (1 bit each, sticky) and input err_clear (1 bit).

Function
REQ-014 SHALL update state only on clk edges with clk_enable=1.
REQ-015 SHALL accept a read iff read=1 and empty=0.
REQ-016 SHALL accept a write iff write=1 and (full=0 or a read is accepted in the same cycle).
REQ-017 SHALL update level +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read+write.
REQ-018 SHALL wrap read/write pointers modulo FIFO_DEPTH.
REQ-019 SHALL derive flags from registered level: empty = (level==0); full = (level==FIFO_DEPTH); almost_full = (level >= FIFO_DEPTH-ALMOSTFULL_DEPTH); almost_empty = (level <= ALMOSTEMPTY_DEPTH).
REQ-020 With FWFT=0, SHALL load read_data with the head entry on the edge accepting a read (latency 1) and hold it otherwise.
REQ-021 With FWFT=1, SHALL present the head entry on read_data whenever empty=0, advance to the next entry on the edge accepting a read, and hold the last value when empty.
REQ-022 SHALL not bypass write_data to read_data while empty; a word is readable no earlier than the cycle after its write.
REQ-023 SHALL ignore rejected requests except for the error flags.

Reset
REQ-024 SHALL, on reset=0, immediately clear pointers, level, read_data, overflow and underflow to 0, set empty=1 and almost_empty=1, and clear full and almost_full, independent of clk and clk_enable.
REQ-025 SHALL discard contents on reset mid-operation; storage array needs no reset.
REQ-026 SHALL accept requests on the first enabled edge after reset deasserts.

Configuration
REQ-027 With macro FIFO_ERROR_FLAGS_EN defined, SHALL set overflow on a rejected write (write=1, full=1, no accepted read) and underflow on a rejected read (read=1, empty=1), both sticky until err_clear=1 on an enabled edge; a new error in the clearing cycle takes priority.
REQ-028 Without FIFO_ERROR_FLAGS_EN, SHALL tie overflow and underflow to 0 and ignore err_clear; ports remain present.

Structure
REQ-029 SHALL place the pointer/level width helper function and the FWFT mode constants in shared package fifo_pkg.
REQ-030 SHALL instantiate one sub-module fifo_ram (simple dual-port: one synchronous write port, asynchronous read port) for storage.

Verification (FIFO_DEPTH=8, width 8, margins 3)
REQ-031 Reset, then write 0..7 -> level 1..8; almost_empty clears at level 4, almost_full sets at level 5, full=1 at level 8.
REQ-032 At full, write 8 with read=0 -> data discarded, level stays 8, overflow=1 (with macro), 0 without.
REQ-033 FWFT=0, from full, read 8 times -> read_data 0..7 one cycle after each accepted read, empty=1 after the eighth; a ninth read sets underflow=1 and read_data holds 7.
REQ-034 At full, simultaneous write 0xAA + read -> both accepted, level stays 8, 0xAA read back last.
REQ-035 FWFT=1, write 0x5A into empty FIFO -> read_data=0x5A the next cycle before any read; read -> empty=1.
REQ-036 Assert reset=0 mid-clock with level=5 -> outputs reach reset values without a clk edge; clk_enable=0 with write=1 -> level unchanged.
